// File: rtl/wb_uart_rx.sv
// 8N1 serial receiver with a small byte FIFO, read and cleared over a
// single-address bus slave that acks once per cycle request.
module wb_uart_rx #(
  parameter int         CLKS_PER_BIT = 139,
  parameter logic [1:0] ADDR         = 2'b10,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        rx,
  input  logic [1:0]  addr,
  input  logic        wb_cyc,
  input  logic        wb_we,
  input  logic [31:0] wb_dat,
  output logic [31:0] rdt,
  output logic        ack
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_IDLE
  } state_t;

  state_t state, state_nxt;

  logic          rx_q1, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;
  logic          push, ferr_set;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic        valid, full;
  logic        do_push, do_pop, ovr_set;
  logic        overrun, ferr;
  logic        sel, served;
  logic        wr_ack;
  logic [7:0]  head;
  logic        unused_bits;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  // Counter fires at 1 so the first sample lands mid start bit.
  assign tick = (cnt == CW'(1));

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP:      if (tick) state_nxt = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
    if (state == STOP && tick) begin
      push     = rx_s;
      ferr_set = !rx_s;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt     <= HALF;
          bit_idx <= '0;
        end
        START: cnt <= tick ? FULL : cnt - CW'(1);
        DATA: begin
          if (tick) begin
            cnt     <= FULL;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP:    cnt <= cnt - CW'(1);
        default: cnt <= HALF;
      endcase
    end
  end

  assign valid   = (count != '0);
  assign full    = (count == DEPTH);
  assign do_pop  = ack & ~wb_we & valid;
  assign do_push = push & (~full | do_pop);
  assign ovr_set = push & full & ~do_pop;
  assign wr_ack  = ack & wb_we;

  always_ff @(posedge wb_clk) begin
    if (do_push) mem[wp] <= shreg;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (ovr_set)                  overrun <= 1'b1;
      else if (wr_ack && wb_dat[9]) overrun <= 1'b0;
      if (ferr_set)                 ferr <= 1'b1;
      else if (wr_ack && wb_dat[10]) ferr <= 1'b0;
    end
  end

  assign sel = wb_cyc & (addr == ADDR);

  // served blocks re-acking until the requester drops wb_cyc.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ack    <= 1'b0;
      served <= 1'b0;
    end else begin
      ack    <= sel & ~ack & ~served;
      served <= wb_cyc & (served | ack);
    end
  end

  assign head = valid ? mem[rp] : 8'h00;
  assign rdt  = ack ? {22'h0, ferr, overrun, valid, head} : 32'h0;

  assign unused_bits = ^{wb_dat[31:11], wb_dat[8:0]};

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed bench for wb_uart_rx: frames driven on rx, results read
// back over the bus and compared with hand-computed status words.
module tb_wb_uart_rx;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        rx;
  logic [1:0]  addr;
  logic        wb_cyc;
  logic        wb_we;
  logic [31:0] wb_dat;
  logic [31:0] rdt;
  logic        ack;

  int checks   = 0;
  int failures = 0;

  always #5 wb_clk = ~wb_clk;

  wb_uart_rx #(
    .CLKS_PER_BIT(4),
    .ADDR(2'b10),
    .FIFO_DEPTH(4)
  ) dut (
    .wb_clk(wb_clk),
    .wb_rst(wb_rst),
    .rx(rx),
    .addr(addr),
    .wb_cyc(wb_cyc),
    .wb_we(wb_we),
    .wb_dat(wb_dat),
    .rdt(rdt),
    .ack(ack)
  );

  task automatic step(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    step(4);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
    rx = 1'b1;
    step(6);
  endtask

  task automatic bus(input logic [1:0] a, input logic we,
                     input logic [31:0] dat, input int hold,
                     output logic [31:0] got, output int acks,
                     output int first);
    got    = 32'hdead_beef;
    acks   = 0;
    first  = -1;
    addr   = a;
    wb_we  = we;
    wb_dat = dat;
    wb_cyc = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge wb_clk);
      if (ack === 1'b1) begin
        if (acks == 0) first = i;
        acks++;
        got = rdt;
      end
      step(1);
    end
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
    wb_dat = '0;
    step(1);
  endtask

  task automatic test_reset();
    logic [31:0] got;
    int n, f;
    wb_rst = 1'b1;
    rx = 1'b1;
    addr = 2'b00;
    wb_cyc = 1'b0;
    wb_we = 1'b0;
    wb_dat = '0;
    step(3);
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack got=%b want=0", ack);
    end
    checks++;
    if (rdt !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdt got=%h want=0", rdt);
    end
    wb_rst = 1'b0;
    step(2);
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (n !== 1 || got !== 32'h000) begin
      failures++;
      $display("FAIL reset_read acks=%0d rdt=%h want 1/000", n, got);
    end
  endtask

  task automatic test_basic();
    logic [31:0] got;
    int n, f;
    send_byte(8'hA5, 1'b1);
    bus(2'b01, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL addr_decode acks=%0d want=0", n);
    end
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (f !== 1 || n !== 1) begin
      failures++;
      $display("FAIL basic_ack first=%0d acks=%0d want 1/1", f, n);
    end
    checks++;
    if (got !== 32'h1A5) begin
      failures++;
      $display("FAIL basic_rdt got=%h want=1a5", got);
    end
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (got !== 32'h000) begin
      failures++;
      $display("FAIL basic_empty got=%h want=000", got);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] got;
    int n, f;
    rx = 1'b0;
    step(1);
    rx = 1'b1;
    step(20);
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (got !== 32'h000) begin
      failures++;
      $display("FAIL glitch got=%h want=000", got);
    end
  endtask

  task automatic test_frame_error();
    logic [31:0] got;
    int n, f;
    send_byte(8'h3C, 1'b0);
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (got !== 32'h400) begin
      failures++;
      $display("FAIL ferr_set got=%h want=400", got);
    end
    bus(2'b10, 1'b1, 32'h400, 3, got, n, f);
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (got !== 32'h000) begin
      failures++;
      $display("FAIL ferr_clear got=%h want=000", got);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] got;
    logic [31:0] want;
    int n, f;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    for (int i = 1; i <= 4; i++) begin
      want = 32'h300 + 32'(i);
      bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL overrun_read%0d got=%h want=%h", i, got, want);
      end
    end
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (got !== 32'h200) begin
      failures++;
      $display("FAIL overrun_empty got=%h want=200", got);
    end
    bus(2'b10, 1'b1, 32'h200, 3, got, n, f);
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (got !== 32'h000) begin
      failures++;
      $display("FAIL overrun_clear got=%h want=000", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int n, f;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    bus(2'b10, 1'b0, 32'h0, 5, got, n, f);
    checks++;
    if (n !== 1 || got !== 32'h111) begin
      failures++;
      $display("FAIL hold_ack acks=%0d rdt=%h want 1/111", n, got);
    end
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (got !== 32'h122) begin
      failures++;
      $display("FAIL hold_second got=%h want=122", got);
    end
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (got !== 32'h000) begin
      failures++;
      $display("FAIL hold_empty got=%h want=000", got);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] got;
    int n, f;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(14);
    wb_rst = 1'b1;
    step(2);
    wb_rst = 1'b0;
    step(40);
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (got !== 32'h000) begin
      failures++;
      $display("FAIL midrst_partial got=%h want=000", got);
    end
    send_byte(8'h55, 1'b1);
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (got !== 32'h155) begin
      failures++;
      $display("FAIL midrst_next got=%h want=155", got);
    end
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (got !== 32'h000) begin
      failures++;
      $display("FAIL midrst_empty got=%h want=000", got);
    end
  endtask

  task automatic test_reset_during_ack();
    logic [31:0] got;
    int n, f;
    send_byte(8'h66, 1'b1);
    addr = 2'b10;
    wb_we = 1'b0;
    wb_cyc = 1'b1;
    @(negedge wb_clk);
    @(negedge wb_clk);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL ackrst_pre got=%b want=1", ack);
    end
    #1 wb_rst = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b0 || rdt !== 32'h0) begin
      failures++;
      $display("FAIL ackrst_force ack=%b rdt=%h want 0/0", ack, rdt);
    end
    step(1);
    wb_cyc = 1'b0;
    wb_rst = 1'b0;
    step(2);
    bus(2'b10, 1'b0, 32'h0, 3, got, n, f);
    checks++;
    if (n !== 1 || got !== 32'h000) begin
      failures++;
      $display("FAIL ackrst_after acks=%0d rdt=%h want 1/000", n, got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_during_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
